p2s_lane_sequencer: RTL and testbench

//  Controller/serializer for the 4-lane parallel-to-serial (p2s) path. Accepts one

---
 rtl/p2s_lane_sequencer.sv | 101 ++++++++++
 tb/tb_p2s_lane_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/p2s_lane_sequencer.sv
// p2s_lane_sequencer: takes one LANES*WIDTH word per handshake and shifts it out
// one bit per lane per cycle, with a one-word pending buffer for gap-free frames.
module p2s_lane_sequencer #(
  parameter int LANES     = 4,
  parameter int WIDTH     = 8,
  parameter int SEL_W     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic                     in_ready,
  input  logic                     halt,
  output logic                     ENB,
  output logic [SEL_W-1:0]         sel,
  output logic [LANES-1:0]         data_out,
  output logic                     out_valid,
  output logic                     frame_start,
  output logic                     busy
);

  localparam logic [SEL_W-1:0] FIRST_SEL = MSB_FIRST ? SEL_W'(WIDTH - 1) : SEL_W'(0);
  localparam logic [SEL_W-1:0] LAST_SEL  = MSB_FIRST ? SEL_W'(0) : SEL_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                   state_q;
  logic [SEL_W-1:0]         sel_q;
  logic [SEL_W-1:0]         sel_d;
  logic [LANES*WIDTH-1:0]   active_q;
  logic [LANES*WIDTH-1:0]   pend_q;
  logic                     pend_v_q;

  logic activeV;
  logic lastBit;
  logic adv;
  logic free;
  logic accept;

  assign activeV  = (state_q == RUN);
  assign lastBit  = activeV & (sel_q == LAST_SEL);
  assign adv      = activeV & ~halt;
  assign free     = ~activeV | (lastBit & ~halt);
  assign in_ready = ~pend_v_q;
  assign accept   = in_valid & in_ready;

  // Step direction follows the serialisation order; only used while mid-frame.
  assign sel_d = MSB_FIRST ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));

  assign ENB         = reset & free & (pend_v_q | accept);
  assign sel         = sel_q;
  assign out_valid   = activeV & ~halt;
  assign frame_start = out_valid & (sel_q == FIRST_SEL);
  assign busy        = activeV | pend_v_q;

  always_comb begin
    data_out = '0;
    for (int k = 0; k < LANES; k++) begin
      if (out_valid) begin
        data_out[k] = active_q[k*WIDTH + int'(sel_q)];
      end
    end
  end

  // Pending always wins the active slot; a fresh word only goes direct when pending is empty.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sel_q    <= FIRST_SEL;
      active_q <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      if (free) begin
        if (pend_v_q) begin
          active_q <= pend_q;
          pend_v_q <= 1'b0;
          state_q  <= RUN;
          sel_q    <= FIRST_SEL;
        end else if (accept) begin
          active_q <= in_data;
          state_q  <= RUN;
          sel_q    <= FIRST_SEL;
        end else begin
          state_q  <= IDLE;
          sel_q    <= FIRST_SEL;
        end
      end else begin
        if (adv) begin
          sel_q <= sel_d;
        end
        if (accept) begin
          pend_q   <= in_data;
          pend_v_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_p2s_lane_sequencer.sv
// tb_p2s_lane_sequencer: directed scenarios plus a random phase, each cycle checked
// against a word/bit-count reference model of the lane serialiser.
module tb_p2s_lane_sequencer;

  localparam int LANES     = 4;
  localparam int WIDTH     = 8;
  localparam int SEL_W     = 3;
  localparam bit MSB_FIRST = 1'b1;

  logic                   CLK = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   in_ready;
  logic                   halt;
  logic                   ENB;
  logic [SEL_W-1:0]       sel;
  logic [LANES-1:0]       data_out;
  logic                   out_valid;
  logic                   frame_start;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mWord;
  bit          mAct;
  int          mCnt;
  logic [31:0] mPendQ[$];

  int  cycleIdx;
  int  obsValidCnt;
  int  obsEnbCnt;
  int  firstValid;
  int  lastValid;
  int  fsCycles[$];
  bit  lane0Bits[$];

  p2s_lane_sequencer #(
    .LANES(LANES), .WIDTH(WIDTH), .SEL_W(SEL_W), .MSB_FIRST(MSB_FIRST)
  ) dut (
    .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .halt(halt), .ENB(ENB), .sel(sel),
    .data_out(data_out), .out_valid(out_valid), .frame_start(frame_start),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mAct = 1'b0;
    mCnt = 0;
    mWord = '0;
    mPendQ.delete();
  endtask

  task automatic clearStats();
    cycleIdx    = 0;
    obsValidCnt = 0;
    obsEnbCnt   = 0;
    firstValid  = -1;
    lastValid   = -1;
    fsCycles.delete();
    lane0Bits.delete();
  endtask

  // One cycle: drive at the falling edge, check settled outputs, advance the model.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic h);
    logic expReady, accept, slotFree, expEnb, expOv, expFs, expBusy;
    logic [SEL_W-1:0] expSel;
    logic [LANES-1:0] expData;
    in_valid = v;
    in_data  = d;
    halt     = h;
    #1;
    expReady = (mPendQ.size() == 0);
    accept   = v && expReady;
    slotFree = !mAct || (!h && mCnt == WIDTH - 1);
    expEnb   = slotFree && (mPendQ.size() != 0 || accept);
    expOv    = mAct && !h;
    expSel   = MSB_FIRST ? SEL_W'(WIDTH - 1 - mCnt) : SEL_W'(mCnt);
    expFs    = expOv && (mCnt == 0);
    expBusy  = mAct || (mPendQ.size() != 0);
    expData  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (expOv) expData[k] = mWord[k*WIDTH + int'(expSel)];
    end
    checkOutput("in_ready", 32'(in_ready), 32'(expReady));
    checkOutput("ENB", 32'(ENB), 32'(expEnb));
    checkOutput("out_valid", 32'(out_valid), 32'(expOv));
    checkOutput("frame_start", 32'(frame_start), 32'(expFs));
    checkOutput("data_out", 32'(data_out), 32'(expData));
    checkOutput("busy", 32'(busy), 32'(expBusy));
    if (mAct) checkOutput("sel", 32'(sel), 32'(expSel));

    if (out_valid === 1'b1) begin
      obsValidCnt++;
      lane0Bits.push_back(data_out[0]);
      if (firstValid < 0) firstValid = cycleIdx;
      lastValid = cycleIdx;
    end
    if (frame_start === 1'b1) fsCycles.push_back(cycleIdx);
    if (ENB === 1'b1) obsEnbCnt++;

    if (mAct && !h) begin
      mCnt++;
      if (mCnt == WIDTH) mAct = 1'b0;
    end
    if (!mAct) begin
      if (mPendQ.size() != 0) begin
        mWord = mPendQ.pop_front();
        mAct  = 1'b1;
        mCnt  = 0;
      end else if (accept) begin
        mWord = d;
        mAct  = 1'b1;
        mCnt  = 0;
      end
    end else if (accept) begin
      mPendQ.push_back(d);
    end
    cycleIdx++;
    @(negedge CLK);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_ENB"}, 32'(ENB), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    checkOutput({tag, "_data_out"}, 32'(data_out), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_sel"}, 32'(sel), 32'd7);
  endtask

  initial begin
    logic [31:0] words[3];
    int accepted;
    bit expLane0[8];
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    halt     = 1'b0;
    modelReset();
    clearStats();

    // Reset held three cycles, then released
    repeat (3) @(negedge CLK);
    checkResetOutputs("rst_held");
    reset = 1'b1;
    #1;
    checkResetOutputs("rst_release");
    @(negedge CLK);

    // Single word, MSB first
    $display("[TB] single word");
    clearStats();
    applyStimulus(1'b1, 32'hA53C0F81, 1'b0);
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b0);
    expLane0 = '{1, 0, 0, 0, 0, 0, 0, 1};
    checkOutput("single_valid_cnt", 32'(obsValidCnt), 32'd8);
    checkOutput("single_first_cycle", 32'(firstValid), 32'd1);
    checkOutput("single_fs_cnt", 32'(fsCycles.size()), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i < lane0Bits.size()) checkOutput($sformatf("single_lane0_bit%0d", i), 32'(lane0Bits[i]), 32'(expLane0[i]));
      else checkOutput($sformatf("single_lane0_bit%0d_missing", i), 32'(lane0Bits.size()), 32'd8);
    end

    // Three words with valid held high
    $display("[TB] back-to-back words");
    clearStats();
    words[0] = $urandom;
    words[1] = $urandom;
    words[2] = $urandom;
    accepted = 0;
    for (int i = 0; i < 30 && accepted < 3; i++) begin
      bit willAccept;
      willAccept = (mPendQ.size() == 0);
      applyStimulus(1'b1, words[accepted], 1'b0);
      if (willAccept) accepted++;
    end
    checkOutput("b2b_accepted", 32'(accepted), 32'd3);
    repeat (30) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("b2b_valid_cnt", 32'(obsValidCnt), 32'd24);
    checkOutput("b2b_contiguous", 32'(lastValid - firstValid + 1), 32'd24);
    checkOutput("b2b_enb_cnt", 32'(obsEnbCnt), 32'd3);
    checkOutput("b2b_fs_cnt", 32'(fsCycles.size()), 32'd3);
    for (int i = 0; i < 3 && i < fsCycles.size(); i++)
      checkOutput($sformatf("b2b_fs_cycle%0d", i), 32'(fsCycles[i]), 32'(1 + 8*i));

    // Halt two cycles at sel=4
    $display("[TB] halt mid-frame");
    clearStats();
    applyStimulus(1'b1, $urandom, 1'b0);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("halt_sel_before", 32'(sel), 32'd4);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("halt_valid_cnt", 32'(obsValidCnt), 32'd8);
    checkOutput("halt_frame_span", 32'(lastValid - firstValid + 1), 32'd10);

    // Accept on last bit with pending empty
    $display("[TB] accept on last bit");
    clearStats();
    applyStimulus(1'b1, $urandom, 1'b0);
    repeat (7) applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, $urandom, 1'b0);
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("lastacc_fs_cnt", 32'(fsCycles.size()), 32'd2);
    if (fsCycles.size() == 2) checkOutput("lastacc_fs_gap", 32'(fsCycles[1] - fsCycles[0]), 32'd8);
    checkOutput("lastacc_valid_span", 32'(lastValid - firstValid + 1), 32'd16);

    // Asynchronous reset mid-frame with pending full
    $display("[TB] async reset mid-frame");
    clearStats();
    applyStimulus(1'b1, $urandom, 1'b0);
    applyStimulus(1'b1, $urandom, 1'b0);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("arst_sel_before", 32'(sel), 32'd2);
    checkOutput("arst_pending_before", 32'(in_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    checkResetOutputs("arst_now");
    modelReset();
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    clearStats();
    repeat (12) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("arst_no_stale", 32'(obsValidCnt), 32'd0);

    // Randomised traffic against the model
    $display("[TB] random traffic");
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 20);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
